enc_issue_ctrl: RTL and testbench

- Issue and sequencing controller for the 3-stage arithmetic-encoder pipeline.
- Accepts symbols from upstream over a valid/ready handshake.
- Enforces the stage-2/stage-3 range-feedback gap by inserting bubbles, and generates per-stage register enables and the initial-state mux select.
- Tracks in-flight valid bits, drains the pipeline at end of frame and runs a flush handshake with the bitstream/carry stage.

---
 rtl/enc_issue_ctrl.sv | 110 +++++++++++
 tb/tb_enc_issue_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/enc_issue_ctrl.sv
// rtl/enc_issue_ctrl.sv - issue/sequencing controller for the 3-stage arithmetic-encoder pipeline
module enc_issue_ctrl #(
    parameter int GAP_CYCLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_ctrl,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             stall,
    output logic             pipeline_reg_1_2,
    output logic             pipeline_reg_2_3,
    output logic             pipeline_reg_final,
    output logic             mux_reset,
    output logic             flush_start,
    input  logic             flush_done,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sym_count
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FLUSH, DONE} state_t;

    localparam logic [2:0] GAP = 3'(GAP_CYCLES);

    state_t     state;
    logic       v1, v2, v3;
    logic [2:0] gap_cnt;
    logic       first;
    logic       accept;
    logic       drained;

    assign in_ready           = ((state == IDLE) || (state == RUN)) && !stall && (gap_cnt == 3'd0);
    assign accept             = in_valid && in_ready;
    assign pipeline_reg_1_2   = accept;
    assign pipeline_reg_2_3   = v1 && !stall;
    assign pipeline_reg_final = v2 && !stall;
    assign mux_reset          = first;
    assign busy               = (state != IDLE);
    assign drained            = !(v1 || v2 || v3) && !stall;

    always_ff @(posedge clk or posedge reset_ctrl) begin
        if (reset_ctrl) begin
            state       <= IDLE;
            v1          <= 1'b0;
            v2          <= 1'b0;
            v3          <= 1'b0;
            gap_cnt     <= 3'd0;
            first       <= 1'b1;
            sym_count   <= '0;
            flush_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (!stall) begin
                v1 <= accept;
                v2 <= v1;
                v3 <= v2;
            end

            // Range feedback from stage 3 must settle before stage 2 sees the next symbol.
            if (accept)
                gap_cnt <= GAP;
            else if (gap_cnt != 3'd0 && !stall)
                gap_cnt <= gap_cnt - 3'd1;

            if (accept) begin
                if (state == IDLE)
                    sym_count <= {{(CNT_W-1){1'b0}}, 1'b1};
                else if (sym_count != '1)
                    sym_count <= sym_count + 1'b1;
            end

            if (pipeline_reg_2_3)
                first <= 1'b0;

            flush_start <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept)
                        state <= in_last ? DRAIN : RUN;
                end
                RUN: begin
                    if (accept && in_last)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (drained) begin
                        state       <= FLUSH;
                        flush_start <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    first <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_issue_ctrl.sv
// tb/tb_enc_issue_ctrl.sv - scoreboard bench for enc_issue_ctrl (GAP 1 and GAP 3 instances)
module tb_enc_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_ctrl, in_valid, in_last, stall, flush_done;

    logic        in_ready_w [2];
    logic        p12_w      [2];
    logic        p23_w      [2];
    logic        pf_w       [2];
    logic        mux_w      [2];
    logic        fs_w       [2];
    logic        busy_w     [2];
    logic        done_w     [2];
    logic [15:0] cnt_w      [2];
    logic [7:0]  act_flags  [2];

    enc_issue_ctrl #(.GAP_CYCLES(1), .CNT_W(16)) u_gap1 (
        .clk(clk), .reset_ctrl(reset_ctrl), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_w[0]), .stall(stall), .pipeline_reg_1_2(p12_w[0]),
        .pipeline_reg_2_3(p23_w[0]), .pipeline_reg_final(pf_w[0]), .mux_reset(mux_w[0]),
        .flush_start(fs_w[0]), .flush_done(flush_done), .busy(busy_w[0]), .done(done_w[0]),
        .sym_count(cnt_w[0])
    );

    enc_issue_ctrl #(.GAP_CYCLES(3), .CNT_W(16)) u_gap3 (
        .clk(clk), .reset_ctrl(reset_ctrl), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_w[1]), .stall(stall), .pipeline_reg_1_2(p12_w[1]),
        .pipeline_reg_2_3(p23_w[1]), .pipeline_reg_final(pf_w[1]), .mux_reset(mux_w[1]),
        .flush_start(fs_w[1]), .flush_done(flush_done), .busy(busy_w[1]), .done(done_w[1]),
        .sym_count(cnt_w[1])
    );

    assign act_flags[0] = {in_ready_w[0], p12_w[0], p23_w[0], pf_w[0], mux_w[0], fs_w[0], busy_w[0], done_w[0]};
    assign act_flags[1] = {in_ready_w[1], p12_w[1], p23_w[1], pf_w[1], mux_w[1], fs_w[1], busy_w[1], done_w[1]};

    typedef struct {
        int          k;
        int          cyc;
        logic [7:0]  flags;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int k;
        int t;
    } sym_t;

    exp_t exp_q [$];
    sym_t infl  [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Frame phase: 0 idle, 1 run, 2 drain, 3 flush, 4 done.
    int phase [2];
    int cool  [2];
    int tick  [2];
    int cnt   [2];
    bit first [2];
    bit fentry[2];
    int gapv  [2];

    function automatic bit has_age(int k, int a);
        foreach (infl[i])
            if (infl[i].k == k && tick[k] - infl[i].t == a)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset(int k);
        phase[k]  = 0;
        cool[k]   = 0;
        cnt[k]    = 0;
        first[k]  = 1'b1;
        fentry[k] = 1'b0;
        for (int i = infl.size() - 1; i >= 0; i--)
            if (infl[i].k == k)
                infl.delete(i);
    endtask

    task automatic model_step(int k, bit iv, bit il, bit st, bit fd);
        bit   rdy, acc, e23, ef, empty;
        exp_t e;
        sym_t s;
        rdy   = (phase[k] <= 1) && !st && (cool[k] == 0);
        acc   = iv && rdy;
        e23   = !st && has_age(k, 1);
        ef    = !st && has_age(k, 2);
        empty = !has_age(k, 1) && !has_age(k, 2) && !has_age(k, 3);
        e.k     = k;
        e.cyc   = cyc;
        e.flags = {rdy, acc, e23, ef, first[k], (phase[k] == 3) && fentry[k], phase[k] != 0, phase[k] == 4};
        e.cnt   = cnt[k][15:0];
        exp_q.push_back(e);

        if (acc) begin
            cnt[k]  = (phase[k] == 0) ? 1 : ((cnt[k] < 65535) ? cnt[k] + 1 : 65535);
            cool[k] = gapv[k];
        end else if (cool[k] > 0 && !st) begin
            cool[k] = cool[k] - 1;
        end
        if (e23)
            first[k] = 1'b0;
        case (phase[k])
            0: if (acc) phase[k] = il ? 2 : 1;
            1: if (acc && il) phase[k] = 2;
            2: if (!st && empty) begin phase[k] = 3; fentry[k] = 1'b1; end
            3: begin fentry[k] = 1'b0; if (fd) phase[k] = 4; end
            default: begin phase[k] = 0; first[k] = 1'b1; end
        endcase
        if (acc) begin
            s.k = k;
            s.t = tick[k];
            infl.push_back(s);
        end
        if (!st)
            tick[k] = tick[k] + 1;
        for (int i = infl.size() - 1; i >= 0; i--)
            if (infl[i].k == k && tick[k] - infl[i].t > 3)
                infl.delete(i);
    endtask

    task automatic step(bit iv, bit il, bit st, bit fd);
        @(negedge clk);
        in_valid   = iv;
        in_last    = il;
        stall      = st;
        flush_done = fd;
        model_step(0, iv, il, st, fd);
        model_step(1, iv, il, st, fd);
        cyc++;
    endtask

    task automatic check_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (act_flags[k] !== 8'b0000_1000 || cnt_w[k] !== 16'd0) begin
                failures++;
                $display("FAIL reset_state inst=%0d flags=%b cnt=%0d required flags=00001000 cnt=0",
                         k, act_flags[k], cnt_w[k]);
            end
        end
    endtask

    // Monitor: pops every expectation issued for the current cycle and compares it with the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act_flags[e.k] !== e.flags || cnt_w[e.k] !== e.cnt) begin
                    failures++;
                    $display("FAIL cycle_outputs inst=%0d cyc=%0d flags[rdy,e12,e23,ef,mux,fs,busy,done]=%b cnt=%0d required flags=%b cnt=%0d",
                             e.k, e.cyc, act_flags[e.k], cnt_w[e.k], e.flags, e.cnt);
                end
            end
        end
    end

    initial begin
        bit did_reset;
        did_reset  = 1'b0;
        gapv[0]    = 1;
        gapv[1]    = 3;
        tick[0]    = 0;
        tick[1]    = 0;
        model_reset(0);
        model_reset(1);
        reset_ctrl = 1'b1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        stall      = 1'b1;
        flush_done = 1'b0;
        repeat (2) @(negedge clk);
        #1 check_reset();
        @(negedge clk);
        reset_ctrl = 1'b0;

        // Four-symbol frame with continuous valid, last on the fourth GAP-1 accept.
        for (int i = 0; i < 8; i++)
            step(1'b1, cnt[0] == 3, 1'b0, 1'b0);
        // flush_done held high through drain: must be ignored until FLUSH.
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1);
        // Single-symbol frame, then a three-cycle stall while symbols are in flight.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b0, 1'b0, i == 6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 6) == 0, ($urandom % 3) == 0);
            if (!did_reset && n > 1500 && phase[0] == 1 && (has_age(0, 1) || has_age(0, 2))) begin
                did_reset = 1'b1;
                #3;
                stall      = 1'b1;
                in_valid   = 1'b0;
                reset_ctrl = 1'b1;
                #1 check_reset();
                model_reset(0);
                model_reset(1);
                @(negedge clk);
                reset_ctrl = 1'b0;
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
